// File: rtl/ws_ctrl_pkg.sv
// Shared constants for the weight-stationary core sequencer: inst bit map,
// array geometry and the FSM/drain state encodings.
package ws_ctrl_pkg;

    localparam int ROW     = 4;
    localparam int COL     = 8;
    localparam int ADDR_W  = 11;
    localparam int TILE_W  = 4;
    localparam int GAP_CYC = 4;
    localparam int XADDR_W = 10;
    localparam int INST_W  = 51;

    localparam int INST_KLOAD     = 0;
    localparam int INST_EXEC      = 1;
    localparam int INST_L0WR      = 2;
    localparam int INST_L0RD      = 3;
    localparam int INST_OFRD      = 6;
    localparam int INST_XADDR_LSB = 7;
    localparam int INST_XADDR_MSB = 16;
    localparam int INST_L0SEL     = 17;
    localparam int INST_XWEN      = 18;
    localparam int INST_XCEN      = 19;
    localparam int INST_PADDR_LSB = 20;
    localparam int INST_PADDR_MSB = 30;
    localparam int INST_PWEN      = 31;
    localparam int INST_PCEN      = 32;
    localparam int INST_ACCUM     = 33;
    localparam int INST_WWEN      = 49;
    localparam int INST_WCEN      = 50;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_LD,
        S_W_KER,
        S_GAP,
        S_X_LD,
        S_X_EXE,
        S_DRAIN
    } seq_state_t;

    // Accumulating tiles: read old psum, pop FIFO, write the sum back.
    typedef enum logic [1:0] {
        PH_RD,
        PH_OFRD,
        PH_WR
    } acc_phase_t;

endpackage

// File: rtl/ws_psum_drain.sv
// Output FIFO to psum memory mover: counts FIFO pops and psum writes and
// sequences the plain (first tile) or read-modify-write (later tiles) path.
module ws_psum_drain
    import ws_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_accum_mode,
    input  logic              i_ofifo_valid,
    input  logic [ADDR_W-1:0] i_nact,
    input  logic [ADDR_W-1:0] i_pbase,
    output logic              o_ofifo_rd,
    output logic              o_pcen,
    output logic              o_pwen,
    output logic              o_accum,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_drain_done
);

    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_psum_cnt;
    logic              r_wr_pend;
    acc_phase_t        r_ph;
    acc_phase_t        w_ph_nxt;
    logic              w_wr;
    logic              w_prd;
    logic              w_more;

    assign w_more = (r_rd_cnt < i_nact);

    always_comb begin
        w_ph_nxt     = r_ph;
        o_ofifo_rd   = 1'b0;
        o_accum      = 1'b0;
        w_prd        = 1'b0;
        w_wr         = 1'b0;
        if (i_accum_mode) begin
            case (r_ph)
                PH_RD: begin
                    w_prd = i_en && i_ofifo_valid && w_more;
                    if (w_prd) w_ph_nxt = PH_OFRD;
                end
                PH_OFRD: begin
                    o_ofifo_rd = i_ofifo_valid;
                    o_accum    = 1'b1;
                    if (i_ofifo_valid) w_ph_nxt = PH_WR;
                end
                PH_WR: begin
                    w_wr     = 1'b1;
                    o_accum  = 1'b1;
                    w_ph_nxt = PH_RD;
                end
                default: w_ph_nxt = PH_RD;
            endcase
        end else begin
            o_ofifo_rd = i_en && i_ofifo_valid && w_more;
            w_wr       = r_wr_pend;
        end
        o_pcen       = !(w_wr || w_prd);
        o_pwen       = !w_wr;
        o_paddr      = (w_wr || w_prd) ? (i_pbase + r_psum_cnt) : '0;
        o_drain_done = w_wr && (r_psum_cnt == (i_nact - 1'b1));
    end

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_rd_cnt   <= '0;
            r_psum_cnt <= '0;
            r_wr_pend  <= 1'b0;
            r_ph       <= PH_RD;
        end else begin
            r_rd_cnt   <= r_rd_cnt + ADDR_W'(o_ofifo_rd);
            r_psum_cnt <= r_psum_cnt + ADDR_W'(w_wr);
            r_wr_pend  <= o_ofifo_rd && !i_accum_mode;
            r_ph       <= w_ph_nxt;
        end
    end

endmodule

// File: rtl/ws_core_sequencer.sv
// Drives the core inst bus through one weight-stationary pass, tile by tile.
// state   | meaning
// IDLE    | waiting for start
// W_LD    | xmem kernel reads into L0 (COL reads + 1 trailing l0_wr)
// W_KER   | push kernel from L0 into the PE array
// GAP     | array settle
// X_LD    | xmem activation reads into L0 (n_act reads + 1 trailing l0_wr)
// X_EXE   | execute; FIFO draining may already begin
// DRAIN   | finish moving psums to pmem
module ws_core_sequencer
    import ws_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [XADDR_W-1:0] w_base,
    input  logic [XADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0]  p_base,
    input  logic [ADDR_W-1:0]  n_act,
    input  logic [TILE_W-1:0]  n_tile,
    input  logic               ofifo_valid,
    output logic [INST_W-1:0]  inst,
    output logic               busy,
    output logic               done
);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [ADDR_W-1:0]  r_tmr;
    logic [ADDR_W-1:0]  w_tmr_nxt;
    logic [TILE_W-1:0]  r_tile;
    logic [TILE_W-1:0]  r_ntile;
    logic [ADDR_W-1:0]  r_nact;
    logic [ADDR_W-1:0]  r_pbase;
    logic [XADDR_W-1:0] r_wptr;
    logic [XADDR_W-1:0] r_xptr;
    logic               r_l0wr;
    logic               w_tmr_zero;
    logic               w_xrd;
    logic [XADDR_W-1:0] w_xaddr;
    logic               w_kload;
    logic               w_exec;
    logic               w_l0rd;
    logic               w_tile_inc;
    logic               w_done;
    logic               w_ofrd;
    logic               w_pcen;
    logic               w_pwen;
    logic               w_accum;
    logic [ADDR_W-1:0]  w_paddr;
    logic               w_drain_done;

    assign w_tmr_zero = (r_tmr == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = w_tmr_zero ? r_tmr : r_tmr - 1'b1;
        w_xrd       = 1'b0;
        w_xaddr     = '0;
        w_kload     = 1'b0;
        w_exec      = 1'b0;
        w_l0rd      = 1'b0;
        w_tile_inc  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_W_LD;
                    w_tmr_nxt   = ADDR_W'(COL);
                end
            end
            S_W_LD: begin
                w_xrd   = !w_tmr_zero;
                w_xaddr = w_xrd ? r_wptr : '0;
                if (w_tmr_zero) begin
                    w_state_nxt = S_W_KER;
                    w_tmr_nxt   = ADDR_W'(COL - 1);
                end
            end
            S_W_KER: begin
                w_kload = 1'b1;
                w_l0rd  = 1'b1;
                if (w_tmr_zero) begin
                    w_state_nxt = S_GAP;
                    w_tmr_nxt   = ADDR_W'(GAP_CYC - 1);
                end
            end
            S_GAP: begin
                if (w_tmr_zero) begin
                    w_state_nxt = S_X_LD;
                    w_tmr_nxt   = r_nact;
                end
            end
            S_X_LD: begin
                w_xrd   = !w_tmr_zero;
                w_xaddr = w_xrd ? r_xptr : '0;
                if (w_tmr_zero) begin
                    w_state_nxt = S_X_EXE;
                    w_tmr_nxt   = r_nact - 1'b1;
                end
            end
            S_X_EXE: begin
                w_exec = 1'b1;
                w_l0rd = 1'b1;
                if (w_tmr_zero) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    if (r_tile == (r_ntile - 1'b1)) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tile_inc  = 1'b1;
                        w_state_nxt = S_W_LD;
                        w_tmr_nxt   = ADDR_W'(COL);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Kernel and activation pointers just keep advancing, so each new tile
    // starts where the previous one stopped without any tile*stride multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_tile  <= '0;
            r_ntile <= '0;
            r_nact  <= '0;
            r_pbase <= '0;
            r_wptr  <= '0;
            r_xptr  <= '0;
            r_l0wr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_l0wr  <= w_xrd;
            if (r_state == S_IDLE && start) begin
                r_nact  <= (n_act == '0) ? ADDR_W'(1) : n_act;
                r_ntile <= (n_tile == '0) ? TILE_W'(1) : n_tile;
                r_pbase <= p_base;
                r_wptr  <= w_base;
                r_xptr  <= x_base;
                r_tile  <= '0;
            end else begin
                if (w_xrd && r_state == S_W_LD) r_wptr <= r_wptr + 1'b1;
                if (w_xrd && r_state == S_X_LD) r_xptr <= r_xptr + 1'b1;
                if (w_tile_inc) r_tile <= r_tile + 1'b1;
            end
        end
    end

    ws_psum_drain u_drain (
        .clk          (clk),
        .reset        (reset),
        .i_en         ((r_state == S_X_EXE) || (r_state == S_DRAIN)),
        .i_clr        ((r_state == S_IDLE) || (r_state == S_W_LD)),
        .i_accum_mode (r_tile != '0),
        .i_ofifo_valid(ofifo_valid),
        .i_nact       (r_nact),
        .i_pbase      (r_pbase),
        .o_ofifo_rd   (w_ofrd),
        .o_pcen       (w_pcen),
        .o_pwen       (w_pwen),
        .o_accum      (w_accum),
        .o_paddr      (w_paddr),
        .o_drain_done (w_drain_done)
    );

    always_comb begin
        inst                                  = '0;
        inst[INST_KLOAD]                      = w_kload;
        inst[INST_EXEC]                       = w_exec;
        inst[INST_L0WR]                       = r_l0wr;
        inst[INST_L0RD]                       = w_l0rd;
        inst[INST_OFRD]                       = w_ofrd;
        inst[INST_XADDR_MSB:INST_XADDR_LSB]   = w_xaddr;
        inst[INST_XWEN]                       = 1'b1;
        inst[INST_XCEN]                       = !w_xrd;
        inst[INST_PADDR_MSB:INST_PADDR_LSB]   = w_paddr;
        inst[INST_PWEN]                       = w_pwen;
        inst[INST_PCEN]                       = w_pcen;
        inst[INST_ACCUM]                      = w_accum;
        inst[INST_WWEN]                       = 1'b1;
        inst[INST_WCEN]                       = 1'b1;
    end

    assign busy = (r_state != S_IDLE);
    assign done = w_done;

endmodule

// File: tb/tb_ws_core_sequencer.sv
// Directed bench for ws_core_sequencer: records every xmem/pmem access from
// the inst bus and compares against hand-derived address/latency tables.
module tb_ws_core_sequencer;

    typedef logic [15:0] q16_t[$];

    localparam logic [50:0] IDLE_INST = (51'd1 << 18) | (51'd1 << 19) | (51'd1 << 31)
                                      | (51'd1 << 32) | (51'd1 << 49) | (51'd1 << 50);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  w_base;
    logic [9:0]  x_base;
    logic [10:0] p_base;
    logic [10:0] n_act;
    logic [3:0]  n_tile;
    logic        ofifo_valid;
    logic [50:0] inst;
    logic        busy;
    logic        done;

    ws_core_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .w_base     (w_base),
        .x_base     (x_base),
        .p_base     (p_base),
        .n_act      (n_act),
        .n_tile     (n_tile),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   vmode   = 0;
    int   vcnt    = 0;
    bit   seen_exec = 0;
    bit   mon_en  = 0;
    int   t_start, t_exec, t_done;
    int   n_done, n_rd, n_wr, n_ofacc;
    int   err_lag, err_ofrd, err_wr, err_acc, err_busy, err_fixed;
    bit   prev_xrd, prev_ofacc, prev_done;
    q16_t xq, pq, ex_x, ex_p;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input q16_t got, input q16_t exp);
        check_eq({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic check_errs(input string tag);
        check_eq({tag, "_l0lag"}, err_lag, 0);
        check_eq({tag, "_ofrd_novalid"}, err_ofrd, 0);
        check_eq({tag, "_wr_no_ofrd"}, err_wr, 0);
        check_eq({tag, "_acc_seq"}, err_acc, 0);
        check_eq({tag, "_busy"}, err_busy, 0);
        check_eq({tag, "_fixed_bits"}, err_fixed, 0);
    endtask

    function automatic void add_x(int base, int n);
        for (int i = 0; i < n; i++) ex_x.push_back(16'((base + i) % 1024));
    endfunction

    function automatic void add_pw(int base, int n, int acc);
        for (int i = 0; i < n; i++)
            ex_p.push_back({3'b0, 1'b1, acc[0], 11'((base + i) % 2048)});
    endfunction

    // FIFO model: after the first execute cycle, valid is held or toggled.
    initial begin
        ofifo_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (vmode)
                1: ofifo_valid = seen_exec;
                2: begin
                    if (seen_exec) begin
                        ofifo_valid = (vcnt % 2 == 0);
                        vcnt++;
                    end else begin
                        ofifo_valid = 1'b0;
                    end
                end
                default: ofifo_valid = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (inst[1] && !seen_exec) begin
                seen_exec = 1'b1;
                t_exec    = cyc;
            end
            if (!inst[19]) xq.push_back({6'b0, inst[16:7]});
            if (inst[2] != prev_xrd) err_lag++;
            prev_xrd = !inst[19] && !reset;
            if (inst[6] && !ofifo_valid) err_ofrd++;
            if (!inst[32]) begin
                pq.push_back({3'b0, ~inst[31], inst[33], inst[30:20]});
                if (!inst[31]) begin
                    if (n_wr >= n_rd) err_wr++;
                    n_wr++;
                    if (inst[33] && !prev_ofacc) err_acc++;
                end
            end
            if (inst[6]) n_rd++;
            if (inst[6] && inst[33]) n_ofacc++;
            prev_ofacc = inst[6] && inst[33];
            if (done) begin
                n_done++;
                t_done = cyc;
                if (!busy) err_busy++;
            end
            if (prev_done && busy) err_busy++;
            prev_done = done;
            if (inst[5:4] != 2'b0 || inst[17] || !inst[18] || inst[37:34] != 4'b0 ||
                inst[48:38] != 11'b0 || !inst[49] || !inst[50])
                err_fixed++;
        end
    end

    task automatic clear_mon();
        xq.delete();
        pq.delete();
        ex_x.delete();
        ex_p.delete();
        n_done = 0; n_rd = 0; n_wr = 0; n_ofacc = 0;
        err_lag = 0; err_ofrd = 0; err_wr = 0; err_acc = 0; err_busy = 0; err_fixed = 0;
        seen_exec = 1'b0;
        vcnt = 0;
        t_exec = 0;
        t_done = 0;
    endtask

    task automatic run(input int wb, input int xb, input int pb, input int na,
                       input int nt, input int vm, input bit disturb);
        clear_mon();
        vmode  = vm;
        w_base = 10'(wb);
        x_base = 10'(xb);
        p_base = 11'(pb);
        n_act  = 11'(na);
        n_tile = 4'(nt);
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        t_start = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq("busy_on_accept", busy, 1);
        if (disturb) begin
            repeat (5) @(posedge clk);
            #1;
            w_base = 10'd500;
            x_base = 10'd300;
            p_base = 11'd7;
            n_act  = 11'd9;
            n_tile = 4'd3;
            start  = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int k = 0; k < 2000 && n_done == 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_eq("done_count", n_done, 1);
        check_eq("busy_after", busy, 0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        w_base = '0;
        x_base = '0;
        p_base = '0;
        n_act  = '0;
        n_tile = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_inst", inst, IDLE_INST);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_mon();
        mon_en = 1'b1;

        // Abort in the middle of kernel load.
        vmode  = 1;
        w_base = 10'd0;
        x_base = 10'd16;
        p_base = 11'd100;
        n_act  = 11'd4;
        n_tile = 4'd1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("abort_inst", inst, IDLE_INST);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        repeat (40) @(negedge clk);
        add_x(0, 3);
        check_q("abort_xrd", xq, ex_x);
        check_eq("abort_pmem_ops", pq.size(), 0);
        check_eq("abort_done_cnt", n_done, 0);
        check_errs("abort");

        // Single tile, valid held high once execute starts.
        run(0, 16, 100, 4, 1, 1, 0);
        add_x(0, 8); add_x(16, 4); add_pw(100, 4, 0);
        check_q("a_xrd", xq, ex_x);
        check_q("a_pmem", pq, ex_p);
        check_eq("a_exec_lat", t_exec - t_start, 27);
        check_eq("a_done_lat", t_done - t_start, 32);
        check_errs("a");

        // Single tile, valid toggling.
        run(0, 16, 100, 4, 1, 2, 0);
        add_x(0, 8); add_x(16, 4); add_pw(100, 4, 0);
        check_q("b_xrd", xq, ex_x);
        check_q("b_pmem", pq, ex_p);
        check_eq("b_ofrd_cnt", n_rd, 4);
        check_eq("b_done_lat", t_done - t_start, 35);
        check_errs("b");

        // Two tiles: second tile accumulates with read/pop/write per psum.
        run(0, 16, 100, 3, 2, 1, 0);
        add_x(0, 8); add_x(16, 3); add_x(8, 8); add_x(19, 3);
        add_pw(100, 3, 0);
        for (int i = 0; i < 3; i++) begin
            ex_p.push_back({3'b0, 1'b0, 1'b0, 11'(100 + i)});
            ex_p.push_back({3'b0, 1'b1, 1'b1, 11'(100 + i)});
        end
        check_q("c_xrd", xq, ex_x);
        check_q("c_pmem", pq, ex_p);
        check_eq("c_ofrd_accum", n_ofacc, 3);
        check_errs("c");

        // Restart and config changes while busy must not disturb the pass.
        run(0, 16, 100, 4, 1, 1, 1);
        add_x(0, 8); add_x(16, 4); add_pw(100, 4, 0);
        check_q("d_xrd", xq, ex_x);
        check_q("d_pmem", pq, ex_p);
        check_eq("d_done_lat", t_done - t_start, 32);
        check_errs("d");

        // xmem and pmem address wrap.
        run(0, 1022, 2046, 4, 1, 1, 0);
        add_x(0, 8); add_x(1022, 4); add_pw(2046, 4, 0);
        check_q("e_xrd", xq, ex_x);
        check_q("e_pmem", pq, ex_p);
        check_eq("e_done_lat", t_done - t_start, 32);
        check_errs("e");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
